// File: rtl/reservation_station_aq_pkg.sv
// Shared defaults and opcode encoding for the age-ordered reservation station.
// The entry struct lives in the top so its field widths follow the instance parameters.
package reservation_station_aq_pkg;

    localparam int RS_DEPTH     = 4;
    localparam int RS_XLEN      = 32;
    localparam int RS_ROB_PTR_W = 3;
    localparam int RS_OP_W      = 4;

    typedef enum logic [RS_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_func_e;

endpackage

// File: rtl/reservation_station_aq_age_matrix_picker.sv
// Age matrix for the reservation station: older_q[e][k]=1 means entry k is older than e.
// Picks the single oldest eligible entry as a one-hot vector.
module reservation_station_aq_age_matrix_picker #(
    parameter int DEPTH = 4
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             flush_in,
    input  logic [DEPTH-1:0] valid_in,
    input  logic [DEPTH-1:0] alloc_oh_in,
    input  logic [DEPTH-1:0] free_oh_in,
    input  logic [DEPTH-1:0] elig_in,
    output logic [DEPTH-1:0] oldest_oh_out
);

    logic [DEPTH-1:0] older_q [DEPTH];

    // A new row snapshots current occupancy, minus anything leaving this same cycle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int e = 0; e < DEPTH; e++) older_q[e] <= '0;
        end else if (flush_in) begin
            for (int e = 0; e < DEPTH; e++) older_q[e] <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (alloc_oh_in[e])
                        older_q[e][k] <= valid_in[k] & ~free_oh_in[k];
                    else if (alloc_oh_in[k] | free_oh_in[k])
                        older_q[e][k] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        oldest_oh_out = '0;
        for (int e = 0; e < DEPTH; e++)
            oldest_oh_out[e] = elig_in[e] & ~(|(older_q[e] & elig_in));
    end

endmodule

// File: rtl/reservation_station_aq.sv
// Age-ordered reservation station: captures operands from the CDB (with issue bypass)
// and hands the oldest ready micro-op to the FU through a registered valid/ready stage.
module reservation_station_aq
    import reservation_station_aq_pkg::*;
#(
    parameter int DEPTH     = RS_DEPTH,
    parameter int XLEN      = RS_XLEN,
    parameter int ROB_PTR_W = RS_ROB_PTR_W,
    parameter int OP_W      = RS_OP_W,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 flush_in,
    input  logic                 issue_valid_in,
    output logic                 issue_ready_out,
    input  logic [ROB_PTR_W-1:0] issue_qi_in,
    input  logic [ROB_PTR_W-1:0] issue_qj_in,
    input  logic [XLEN-1:0]      issue_vi_in,
    input  logic [XLEN-1:0]      issue_vj_in,
    input  logic                 issue_i_ready_in,
    input  logic                 issue_j_ready_in,
    input  logic [ROB_PTR_W-1:0] issue_rob_ix_in,
    input  logic [OP_W-1:0]      issue_opcode_in,
    input  logic                 cdb_valid_in,
    input  logic [ROB_PTR_W-1:0] cdb_rob_ix_in,
    input  logic [XLEN-1:0]      cdb_value_in,
    output logic                 disp_valid_out,
    input  logic                 disp_ready_in,
    output logic [XLEN-1:0]      disp_vi_out,
    output logic [XLEN-1:0]      disp_vj_out,
    output logic [OP_W-1:0]      disp_opcode_out,
    output logic [ROB_PTR_W-1:0] disp_rob_ix_out,
    output logic [CNT_W-1:0]     count_out
);

    typedef struct packed {
        logic [ROB_PTR_W-1:0] qi;
        logic [ROB_PTR_W-1:0] qj;
        logic [XLEN-1:0]      vi;
        logic [XLEN-1:0]      vj;
        logic                 i_rdy;
        logic                 j_rdy;
        logic [ROB_PTR_W-1:0] rob_ix;
        logic [OP_W-1:0]      opcode;
    } rs_entry_t;

    rs_entry_t        ent_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [CNT_W-1:0] count_q;
    logic             disp_valid_q;

    logic [DEPTH-1:0] alloc_oh, free_oh, elig, oldest_oh;
    logic             issue_fire, disp_load, take, alloc_found;
    logic             byp_i, byp_j;
    rs_entry_t        new_ent, sel_ent;

    assign issue_ready_out = (count_q < CNT_W'(DEPTH));
    assign issue_fire      = issue_valid_in & issue_ready_out;
    assign disp_load       = ~disp_valid_q | disp_ready_in;
    assign free_oh         = oldest_oh & {DEPTH{disp_load}};
    assign take            = |free_oh;

    always_comb begin
        alloc_oh    = '0;
        alloc_found = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
            if (!valid_q[e] && !alloc_found) begin
                alloc_oh[e] = issue_fire;
                alloc_found = 1'b1;
            end
        end
    end

    always_comb begin
        elig = '0;
        for (int e = 0; e < DEPTH; e++)
            elig[e] = valid_q[e] & ent_q[e].i_rdy & ent_q[e].j_rdy;
    end

    // Operands produced on the CDB in the issue cycle are captured directly.
    always_comb begin
        byp_i          = ~issue_i_ready_in & cdb_valid_in & (cdb_rob_ix_in == issue_qi_in);
        byp_j          = ~issue_j_ready_in & cdb_valid_in & (cdb_rob_ix_in == issue_qj_in);
        new_ent.qi     = issue_qi_in;
        new_ent.qj     = issue_qj_in;
        new_ent.vi     = byp_i ? cdb_value_in : issue_vi_in;
        new_ent.vj     = byp_j ? cdb_value_in : issue_vj_in;
        new_ent.i_rdy  = issue_i_ready_in | byp_i;
        new_ent.j_rdy  = issue_j_ready_in | byp_j;
        new_ent.rob_ix = issue_rob_ix_in;
        new_ent.opcode = issue_opcode_in;
    end

    always_comb begin
        sel_ent = '0;
        for (int e = 0; e < DEPTH; e++)
            if (oldest_oh[e]) sel_ent = sel_ent | ent_q[e];
    end

    reservation_station_aq_age_matrix_picker #(.DEPTH(DEPTH)) u_picker (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .flush_in      (flush_in),
        .valid_in      (valid_q),
        .alloc_oh_in   (alloc_oh),
        .free_oh_in    (free_oh),
        .elig_in       (elig),
        .oldest_oh_out (oldest_oh)
    );

    // Ready operands are never overwritten; only waiting ones snoop the CDB.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q <= '0;
            for (int e = 0; e < DEPTH; e++) ent_q[e] <= '0;
        end else if (flush_in) begin
            valid_q <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (alloc_oh[e]) begin
                    valid_q[e] <= 1'b1;
                    ent_q[e]   <= new_ent;
                end else begin
                    if (free_oh[e]) valid_q[e] <= 1'b0;
                    if (valid_q[e] && cdb_valid_in) begin
                        if (!ent_q[e].i_rdy && ent_q[e].qi == cdb_rob_ix_in) begin
                            ent_q[e].vi    <= cdb_value_in;
                            ent_q[e].i_rdy <= 1'b1;
                        end
                        if (!ent_q[e].j_rdy && ent_q[e].qj == cdb_rob_ix_in) begin
                            ent_q[e].vj    <= cdb_value_in;
                            ent_q[e].j_rdy <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            disp_valid_q    <= 1'b0;
            disp_vi_out     <= '0;
            disp_vj_out     <= '0;
            disp_opcode_out <= '0;
            disp_rob_ix_out <= '0;
        end else if (flush_in) begin
            disp_valid_q <= 1'b0;
        end else if (disp_load) begin
            disp_valid_q <= take;
            if (take) begin
                disp_vi_out     <= sel_ent.vi;
                disp_vj_out     <= sel_ent.vj;
                disp_opcode_out <= sel_ent.opcode;
                disp_rob_ix_out <= sel_ent.rob_ix;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            count_q <= '0;
        else if (flush_in)
            count_q <= '0;
        else
            count_q <= count_q + {{(CNT_W-1){1'b0}}, issue_fire} - {{(CNT_W-1){1'b0}}, take};
    end

    assign disp_valid_out = disp_valid_q;
    assign count_out      = count_q;

endmodule

// File: tb/tb_reservation_station_aq.sv
// Bench for reservation_station_aq: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an age-stamp queue model.
module tb_reservation_station_aq;
    import reservation_station_aq_pkg::*;

    localparam int D = 4;

    logic        clk_in = 0, rst_n_in = 0, flush_in = 0;
    logic        issue_valid_in = 0, issue_ready_out;
    logic [2:0]  issue_qi_in = 0, issue_qj_in = 0, issue_rob_ix_in = 0;
    logic [31:0] issue_vi_in = 0, issue_vj_in = 0;
    logic        issue_i_ready_in = 0, issue_j_ready_in = 0;
    logic [3:0]  issue_opcode_in = 0;
    logic        cdb_valid_in = 0;
    logic [2:0]  cdb_rob_ix_in = 0;
    logic [31:0] cdb_value_in = 0;
    logic        disp_valid_out, disp_ready_in = 0;
    logic [31:0] disp_vi_out, disp_vj_out;
    logic [3:0]  disp_opcode_out;
    logic [2:0]  disp_rob_ix_out;
    logic [2:0]  count_out;

    reservation_station_aq dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .flush_in(flush_in),
        .issue_valid_in(issue_valid_in), .issue_ready_out(issue_ready_out),
        .issue_qi_in(issue_qi_in), .issue_qj_in(issue_qj_in),
        .issue_vi_in(issue_vi_in), .issue_vj_in(issue_vj_in),
        .issue_i_ready_in(issue_i_ready_in), .issue_j_ready_in(issue_j_ready_in),
        .issue_rob_ix_in(issue_rob_ix_in), .issue_opcode_in(issue_opcode_in),
        .cdb_valid_in(cdb_valid_in), .cdb_rob_ix_in(cdb_rob_ix_in), .cdb_value_in(cdb_value_in),
        .disp_valid_out(disp_valid_out), .disp_ready_in(disp_ready_in),
        .disp_vi_out(disp_vi_out), .disp_vj_out(disp_vj_out),
        .disp_opcode_out(disp_opcode_out), .disp_rob_ix_out(disp_rob_ix_out),
        .count_out(count_out)
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0, n_err = 0;
    bit cmp_on = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a set of slots, each tagged with an issue sequence number; oldest = smallest tag.
    bit          mv [D];
    int          mage [D];
    bit          mir [D], mjr [D];
    logic [2:0]  mqi [D], mqj [D], mrob [D];
    logic [31:0] mvi [D], mvj [D];
    logic [3:0]  mop [D];
    bit          md_v;
    logic [31:0] md_vi, md_vj;
    logic [3:0]  md_op;
    logic [2:0]  md_rob;
    int          seq_no = 0;
    int          m_sel, m_free;
    bit          m_fire;

    function automatic int occ();
        int n = 0;
        for (int i = 0; i < D; i++) n += int'(mv[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < D; i++) mv[i] = 0;
        md_v = 0; md_vi = 0; md_vj = 0; md_op = 0; md_rob = 0;
    endtask

    task automatic model_step();
        if (!rst_n_in) begin model_reset(); return; end
        if (flush_in) begin
            for (int i = 0; i < D; i++) mv[i] = 0;
            md_v = 0;
            return;
        end
        m_sel = -1; m_free = -1;
        for (int i = 0; i < D; i++)
            if (mv[i] && mir[i] && mjr[i] && (m_sel < 0 || mage[i] < mage[m_sel])) m_sel = i;
        for (int i = D - 1; i >= 0; i--) if (!mv[i]) m_free = i;
        m_fire = issue_valid_in && (occ() < D);
        if (!md_v || disp_ready_in) begin
            if (m_sel >= 0) begin
                md_v = 1; md_vi = mvi[m_sel]; md_vj = mvj[m_sel];
                md_op = mop[m_sel]; md_rob = mrob[m_sel]; mv[m_sel] = 0;
            end else md_v = 0;
        end
        for (int i = 0; i < D; i++) if (mv[i] && cdb_valid_in) begin
            if (!mir[i] && mqi[i] == cdb_rob_ix_in) begin mir[i] = 1; mvi[i] = cdb_value_in; end
            if (!mjr[i] && mqj[i] == cdb_rob_ix_in) begin mjr[i] = 1; mvj[i] = cdb_value_in; end
        end
        if (m_fire) begin
            mv[m_free] = 1; mage[m_free] = seq_no++;
            mqi[m_free] = issue_qi_in; mqj[m_free] = issue_qj_in;
            mrob[m_free] = issue_rob_ix_in; mop[m_free] = issue_opcode_in;
            mir[m_free] = issue_i_ready_in; mvi[m_free] = issue_vi_in;
            mjr[m_free] = issue_j_ready_in; mvj[m_free] = issue_vj_in;
            if (!issue_i_ready_in && cdb_valid_in && cdb_rob_ix_in == issue_qi_in) begin
                mir[m_free] = 1; mvi[m_free] = cdb_value_in;
            end
            if (!issue_j_ready_in && cdb_valid_in && cdb_rob_ix_in == issue_qj_in) begin
                mjr[m_free] = 1; mvj[m_free] = cdb_value_in;
            end
        end
    endtask

    initial forever begin @(posedge clk_in); model_step(); end
    initial forever begin @(negedge rst_n_in); model_reset(); end

    initial forever begin
        @(negedge clk_in);
        if (cmp_on) begin
            chk("count", 64'(count_out), 64'(occ()));
            chk("issue_ready", 64'(issue_ready_out), 64'(occ() < D));
            chk("disp_valid", 64'(disp_valid_out), 64'(md_v));
            if (md_v) begin
                chk("disp_vi", 64'(disp_vi_out), 64'(md_vi));
                chk("disp_vj", 64'(disp_vj_out), 64'(md_vj));
                chk("disp_op", 64'(disp_opcode_out), 64'(md_op));
                chk("disp_rob", 64'(disp_rob_ix_out), 64'(md_rob));
            end
        end
    end

    task automatic tick(); @(posedge clk_in); #1; endtask

    task automatic idle();
        issue_valid_in = 0; cdb_valid_in = 0; flush_in = 0;
    endtask

    task automatic issue(input logic [2:0] rob, input logic [3:0] op,
                         input bit ir, input logic [2:0] qi, input logic [31:0] vi,
                         input bit jr, input logic [2:0] qj, input logic [31:0] vj);
        issue_valid_in = 1; issue_rob_ix_in = rob; issue_opcode_in = op;
        issue_i_ready_in = ir; issue_qi_in = qi; issue_vi_in = vi;
        issue_j_ready_in = jr; issue_qj_in = qj; issue_vj_in = vj;
    endtask

    task automatic cdb(input logic [2:0] rob, input logic [31:0] val);
        cdb_valid_in = 1; cdb_rob_ix_in = rob; cdb_value_in = val;
    endtask

    initial begin
        tick(); tick();
        rst_n_in = 1;
        cmp_on = 1;
        tick();
        chk("rst_count", 64'(count_out), 0);
        chk("rst_ready", 64'(issue_ready_out), 1);
        chk("rst_dvalid", 64'(disp_valid_out), 0);

        // minimum latency, both operands ready
        disp_ready_in = 1;
        issue(3'd2, ALU_ADD, 1, 0, 32'd5, 1, 0, 32'd7);
        tick(); idle();
        chk("lat_count1", 64'(count_out), 1);
        tick();
        chk("lat_dvalid", 64'(disp_valid_out), 1);
        chk("lat_vi", 64'(disp_vi_out), 5);
        chk("lat_vj", 64'(disp_vj_out), 7);
        chk("lat_rob", 64'(disp_rob_ix_out), 2);
        chk("lat_op", 64'(disp_opcode_out), 64'(ALU_ADD));
        chk("lat_count0", 64'(count_out), 0);
        tick();

        // wakeup from CDB, then the same with issue-cycle bypass
        issue(3'd1, ALU_SUB, 0, 3'd3, 32'd0, 1, 0, 32'd7);
        tick(); idle(); tick(); tick();
        chk("wait_dvalid", 64'(disp_valid_out), 0);
        cdb(3'd3, 32'h10);
        tick(); idle(); tick();
        chk("wake_dvalid", 64'(disp_valid_out), 1);
        chk("wake_vi", 64'(disp_vi_out), 32'h10);
        chk("wake_vj", 64'(disp_vj_out), 7);
        tick();
        issue(3'd1, ALU_SUB, 0, 3'd3, 32'd0, 1, 0, 32'd7);
        cdb(3'd3, 32'h10);
        tick(); idle(); tick();
        chk("byp_dvalid", 64'(disp_valid_out), 1);
        chk("byp_vi", 64'(disp_vi_out), 32'h10);
        tick();

        // fill, hold, ordered drain, full refusal, refill
        disp_ready_in = 0;
        for (int r = 0; r < 4; r++) begin
            issue(3'(r), ALU_ADD, 0, 3'd5, 32'd0, 1, 0, 32'(100 + r));
            tick();
        end
        idle();
        chk("full_count", 64'(count_out), 4);
        chk("full_ready", 64'(issue_ready_out), 0);
        cdb(3'd5, 32'h55);
        tick(); idle();
        chk("full_dvalid0", 64'(disp_valid_out), 0);
        issue(3'd6, ALU_OR, 1, 0, 32'd6, 1, 0, 32'd6);
        tick();
        chk("hold_rob_a", 64'(disp_rob_ix_out), 0);
        chk("hold_vi", 64'(disp_vi_out), 32'h55);
        chk("refused_count", 64'(count_out), 3);
        tick(); idle();
        chk("hold_rob_b", 64'(disp_rob_ix_out), 0);
        chk("accept_count", 64'(count_out), 4);
        tick();
        chk("hold_rob_c", 64'(disp_rob_ix_out), 0);
        disp_ready_in = 1;
        tick();
        chk("order_1", 64'(disp_rob_ix_out), 1);
        issue(3'd4, ALU_XOR, 1, 0, 32'd4, 1, 0, 32'd4);
        tick(); idle();
        chk("order_2", 64'(disp_rob_ix_out), 2);
        tick();
        chk("order_3", 64'(disp_rob_ix_out), 3);
        tick();
        chk("order_6", 64'(disp_rob_ix_out), 6);
        tick();
        chk("order_4", 64'(disp_rob_ix_out), 4);
        tick();
        chk("drain_dvalid", 64'(disp_valid_out), 0);
        chk("drain_count", 64'(count_out), 0);

        // flush with issue and a held dispatch
        disp_ready_in = 0;
        issue(3'd7, ALU_AND, 1, 0, 32'd1, 1, 0, 32'd2);
        tick(); idle(); tick();
        chk("pre_flush_dv", 64'(disp_valid_out), 1);
        issue(3'd3, ALU_AND, 1, 0, 32'd3, 1, 0, 32'd3);
        flush_in = 1;
        tick(); idle();
        chk("flush_count", 64'(count_out), 0);
        chk("flush_dvalid", 64'(disp_valid_out), 0);
        disp_ready_in = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_flush_dv", 64'(disp_valid_out), 0);
        end

        // async reset mid-traffic
        disp_ready_in = 0;
        for (int r = 0; r < 3; r++) begin
            issue(3'(r), ALU_ADD, 0, 3'd6, 32'd0, 0, 3'd6, 32'd0);
            tick();
        end
        idle();
        chk("pre_rst_count", 64'(count_out), 3);
        #2 rst_n_in = 0;
        #1;
        chk("arst_count", 64'(count_out), 0);
        chk("arst_dvalid", 64'(disp_valid_out), 0);
        chk("arst_ready", 64'(issue_ready_out), 1);
        tick();
        rst_n_in = 1;

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            issue_valid_in   = ($urandom_range(0, 2) != 0);
            issue_rob_ix_in  = 3'($urandom_range(0, 7));
            issue_opcode_in  = 4'($urandom_range(0, 9));
            issue_i_ready_in = $urandom_range(0, 1) == 1;
            issue_j_ready_in = $urandom_range(0, 1) == 1;
            issue_qi_in      = 3'($urandom_range(0, 7));
            issue_qj_in      = 3'($urandom_range(0, 7));
            issue_vi_in      = $urandom;
            issue_vj_in      = $urandom;
            cdb_valid_in     = $urandom_range(0, 1) == 1;
            cdb_rob_ix_in    = 3'($urandom_range(0, 7));
            cdb_value_in     = $urandom;
            disp_ready_in    = ($urandom_range(0, 3) != 0);
            flush_in         = ($urandom_range(0, 63) == 0);
            tick();
        end
        idle();
        @(negedge clk_in); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
